// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key layout, candidate encodings
// and the accepted-key state type.
package keypad_pkg;

  // Candidate is {flag, code}: flag=0 means a single valid key with hex code.
  typedef logic [4:0] cand_t;

  localparam cand_t CAND_NONE    = 5'h10;
  localparam cand_t CAND_INVALID = 5'h1F;

  // KEYMAP[row][col] -> hex code printed on the keypad
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  typedef enum logic {
    KEY_UP,
    KEY_DOWN
  } key_state_e;

endpackage

// File: rtl/keypad_decode.sv
// Combinational decode of one full 16-bit scan map (bit 4*col+row = pressed)
// into a single-key candidate, NONE, or INVALID for multiple keys.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [15:0] map,
  output logic [4:0]  cand
);

  logic [4:0] hits;

  always_comb begin
    hits = '0;
    cand = CAND_NONE;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (map[4*c+r]) begin
          hits = hits + 5'd1;
          cand = {1'b0, KEYMAP[r][c]};
        end
      end
    end
    if (hits > 5'd1) cand = CAND_INVALID;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: active-low column drive, synchronized row sampling,
// per-scan decode and debounce producing a hex key code with a press strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [15:0]   map, scan_map;
  logic          scan_done;
  logic [4:0]    cand;

  key_state_e    state, state_next;
  logic [3:0]    code_next;
  logic [CW-1:0] cnt, cnt_next;
  cand_t         prev, prev_next;
  cand_t         accepted;
  logic          valid_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // The completed map is registered so decode sees all four columns at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell     <= '0;
      col_idx   <= '0;
      map       <= '0;
      scan_map  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (dwell == DWELL_LAST) begin
        dwell                <= '0;
        col_idx              <= col_idx + 2'd1;
        map[4*col_idx +: 4]  <= ~row_sync;
        if (col_idx == 2'd3) begin
          scan_map  <= {~row_sync, map[11:0]};
          scan_done <= 1'b1;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  assign col = ~(4'b0001 << col_idx);

  keypad_decode u_decode (
    .map  (scan_map),
    .cand (cand)
  );

  assign accepted = (state == KEY_DOWN) ? {1'b0, key_code} : CAND_NONE;

  always_comb begin
    state_next = state;
    code_next  = key_code;
    cnt_next   = cnt;
    prev_next  = prev;
    valid_next = 1'b0;
    if (scan_done) begin
      if (cand == CAND_INVALID) begin
        cnt_next = '0;
      end else begin
        prev_next = cand;
        if (cand == prev) cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        else              cnt_next = CW'(1);
        if (cnt_next == CNT_MAX && cand != accepted) begin
          if (cand == CAND_NONE) begin
            state_next = KEY_UP;
          end else begin
            state_next = KEY_DOWN;
            code_next  = cand[3:0];
            valid_next = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= KEY_UP;
      key_code  <= '0;
      cnt       <= '0;
      prev      <= CAND_NONE;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      key_code  <= code_next;
      cnt       <= cnt_next;
      prev      <= prev_next;
      key_valid <= valid_next;
    end
  end

  assign key_held = (state == KEY_DOWN);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scenario table,
// hand-written reset sequence and randomized key patterns against a scan-level model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // keys bit (r*4 + c) set means key at row r, column c is held down
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Scan-level reference: a key is accepted once the trailing DB candidates
  // (since the last multi-key scan) agree and differ from the accepted state.
  string       keymap_str = "123A456B789C0FED";
  int          hist[$];
  logic        m_down;
  logic [3:0]  m_code;
  int          exp_pulse;

  function automatic int key_value(input int idx);
    byte ch;
    ch = keymap_str[idx];
    return (ch >= "A") ? int'(ch - "A") + 10 : int'(ch - "0");
  endfunction

  task automatic model_reset();
    hist.delete();
    m_down = 1'b0;
    m_code = 4'h0;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int cand, acc;
    bit agree;
    exp_pulse = 0;
    if ($countones(k) > 1) begin
      hist.delete();
      return;
    end
    cand = 16;
    for (int i = 0; i < 16; i++) if (k[i]) cand = key_value(i);
    hist.push_back(cand);
    if (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() < DB) return;
    agree = 1'b1;
    foreach (hist[i]) if (hist[i] != cand) agree = 1'b0;
    acc = m_down ? int'(m_code) : 16;
    if (agree && cand != acc) begin
      if (cand == 16) m_down = 1'b0;
      else begin
        m_down    = 1'b1;
        m_code    = cand[3:0];
        exp_pulse = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered on the negedge after the first edge of a scan; returns one scan later.
  task automatic run_scan(input logic [15:0] k, output int pulses);
    logic       col_ok, dbl, pkv, code_ok;
    logic [3:0] ec;
    keys = k;
    model_scan(k);
    pulses = 0; col_ok = 1'b1; dbl = 1'b0; pkv = 1'b0; code_ok = 1'b1;
    for (int j = 2; j <= 17; j++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((j / 4) % 4));
      if (col !== ec) col_ok = 1'b0;
      if (key_valid) begin
        pulses++;
        if (pkv) dbl = 1'b1;
        if (key_code !== m_code) code_ok = 1'b0;
      end
      pkv = key_valid;
    end
    check("col_sequence", {31'd0, col_ok}, 32'd1);
    check("no_back_to_back_valid", {31'd0, dbl}, 32'd0);
    check("pulses_per_scan", pulses, exp_pulse);
    check("code_at_strobe", {31'd0, code_ok}, 32'd1);
    check("key_code_after_scan", {28'd0, key_code}, {28'd0, m_code});
    check("key_held_after_scan", {31'd0, key_held}, {31'd0, m_down});
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check("reset_col", {28'd0, col}, 32'hE);
    check("reset_key_code", {28'd0, key_code}, 32'h0);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_key_held", {31'd0, key_held}, 32'd0);
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [15:0] k;
    int          scans;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
  } step_t;

  step_t steps[$];

  initial begin
    int p, total;
    logic [15:0] rk;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset(2);

    // key bits: '5'=5 'A'=3 '1'=0 '2'=1 '7'=8 '9'=10 'D'=15
    steps.push_back('{"idle",         16'h0000, 2, 0, 4'h0, 1'b0});
    steps.push_back('{"hold_5",       16'h0020, 3, 1, 4'h5, 1'b1});
    steps.push_back('{"release_5",    16'h0000, 2, 0, 4'h5, 1'b0});
    steps.push_back('{"tap_A",        16'h0008, 1, 0, 4'h5, 1'b0});
    steps.push_back('{"after_tap_A",  16'h0000, 2, 0, 4'h5, 1'b0});
    steps.push_back('{"two_keys",     16'h0003, 4, 0, 4'h5, 1'b0});
    steps.push_back('{"idle2",        16'h0000, 1, 0, 4'h5, 1'b0});
    steps.push_back('{"hold_7",       16'h0100, 2, 1, 4'h7, 1'b1});
    steps.push_back('{"roll_9",       16'h0400, 3, 1, 4'h9, 1'b1});
    steps.push_back('{"release_9",    16'h0000, 2, 0, 4'h9, 1'b0});
    steps.push_back('{"hold_5b",      16'h0020, 2, 1, 4'h5, 1'b1});
    steps.push_back('{"two_keys_held",16'h0003, 4, 0, 4'h5, 1'b1});
    steps.push_back('{"release_5b",   16'h0000, 2, 0, 4'h5, 1'b0});
    steps.push_back('{"hold_D",       16'h8000, 2, 1, 4'hD, 1'b1});

    foreach (steps[i]) begin
      total = 0;
      for (int s = 0; s < steps[i].scans; s++) begin
        run_scan(steps[i].k, p);
        total += p;
      end
      check({steps[i].name, "_pulses"}, total, steps[i].exp_pulses);
      check({steps[i].name, "_code"}, {28'd0, key_code}, {28'd0, steps[i].exp_code});
      check({steps[i].name, "_held"}, {31'd0, key_held}, {31'd0, steps[i].exp_held});
    end

    // Reset mid-scan with 'D' still held: cleared, then re-detected after two scans.
    repeat (5) @(negedge clk);
    do_reset(3);
    run_scan(16'h8000, p);
    check("d_after_reset_scan1_pulses", p, 0);
    check("d_after_reset_scan1_held", {31'd0, key_held}, 32'd0);
    run_scan(16'h8000, p);
    check("d_after_reset_scan2_pulses", p, 1);
    check("d_after_reset_code", {28'd0, key_code}, 32'hD);
    check("d_after_reset_held", {31'd0, key_held}, 32'd1);

    for (int n = 0; n < 60; n++) begin
      int sel, hold;
      sel = $urandom_range(0, 99);
      if (sel < 45)      rk = '0;
      else if (sel < 85) rk = 16'h1 << $urandom_range(0, 15);
      else               rk = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      hold = $urandom_range(1, 3);
      for (int s = 0; s < hold; s++) run_scan(rk, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
